// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, ALU/writeback encodings and decode helpers
// Purpose: common definitions for the single-cycle RV32I core.
// Contents: RV32I major opcodes, alu_op_t, wb_sel_t, immediate and ALU-op helpers.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // WB_NONE means the instruction has no architectural register result.
  typedef enum logic [2:0] {
    WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCIMM
  } wb_sel_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_rv32i_if.sv
// rtl/core_rv32i_if.sv - instruction/data memory bus between core and memories
// Purpose: groups the ROM fetch port and RAM load/store port of the core.
// Signals: iaddr/idata (fetch), daddr/ddata_w/ddata_r (data), MemRead/MemWrite/d_rw (strobes).
// Modports: master = core side, slave = memory side.
interface core_rv32i_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] iaddr;
  logic [DATA_WIDTH-1:0] idata;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] ddata_w;
  logic [DATA_WIDTH-1:0] ddata_r;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  d_rw;

  modport master (
    output iaddr, daddr, ddata_w, MemRead, MemWrite, d_rw,
    input  idata, ddata_r
  );

  modport slave (
    input  iaddr, daddr, ddata_w, MemRead, MemWrite, d_rw,
    output idata, ddata_r
  );
endinterface

// File: rtl/core_alu.sv
// rtl/core_alu.sv - 32-bit RV32I integer ALU
// Purpose: combinational arithmetic/logic/shift/compare unit.
// Ports: a, b (operands), op (alu_op_t), y (result), zero (y == 0).
module core_alu
  import core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/core_rv32i.sv
// rtl/core_rv32i.sv - single-cycle RV32I integer core
// Purpose: fetches from an async ROM, executes one instruction per CLK edge,
//          loads/stores a word-addressed RAM (sync write, comb read).
// Ports: CLK (clock), RESET_N (async active-low reset),
//        bus (core_rv32i_if.master: iaddr/idata, daddr/ddata_w/ddata_r, MemRead/MemWrite/d_rw).
// Option: CORE_REGFILE_CLEAR_EN - when defined x1..x31 are cleared by RESET_N,
//         otherwise only the PC is reset.
module core_rv32i
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  core_rv32i_if.master bus
);

  logic [ADDR_WIDTH-1:0] pc, pc_plus4, pc_imm, next_pc;
  logic [DATA_WIDTH-1:0] regs [32];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_off;

  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, alu_b, alu_y, wb_data;
  alu_op_t alu_op;
  wb_sel_t wb_sel;
  logic    alu_zero, mem_rd, mem_wr, is_branch, is_jal, is_jalr, taken, reg_we;

  assign instr  = bus.idata;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alt    = instr[30];

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Decoder. Anything not matched leaves the defaults, which form a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_b     = rs2_val;
    wb_sel    = WB_NONE;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI:   wb_sel = WB_IMM;
      OP_AUIPC: wb_sel = WB_PCIMM;
      OP_JAL: begin
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
        alu_b   = imm_i;
      end
      OP_BRANCH: begin
        // funct3[2:1]: 00 eq/ne via SUB+zero, 10 signed, 11 unsigned; 01 is illegal.
        is_branch = 1'b1;
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: is_branch = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          mem_rd = 1'b1;
          wb_sel = WB_MEM;
          alu_b  = imm_i;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          mem_wr = 1'b1;
          alu_b  = imm_s;
        end
      end
      OP_IMM: begin
        // imm[10] is only an opcode modifier for SRAI; ADDI never becomes SUB.
        alu_b  = imm_i;
        alu_op = alu_from_f3(funct3, alt && (funct3 == 3'b101));
        wb_sel = WB_ALU;
      end
      OP_REG: begin
        alu_op = alu_from_f3(funct3, alt);
        wb_sel = WB_ALU;
      end
      default: ;
    endcase
  end

  core_alu u_alu (
    .a    (rs1_val),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // funct3[2] picks the compare result over the equality flag, funct3[0] inverts.
  assign taken = is_branch && ((funct3[2] ? alu_y[0] : alu_zero) ^ funct3[0]);

  assign pc_plus4 = pc + 32'd4;
  assign pc_off   = is_jal ? imm_j : (is_branch ? imm_b : imm_u);
  assign pc_imm   = pc + pc_off;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jalr)
      next_pc = {alu_y[31:1], 1'b0};
    else if (is_jal || taken)
      next_pc = pc_imm;
  end

  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:   wb_data = bus.ddata_r;
      WB_PC4:   wb_data = pc_plus4;
      WB_IMM:   wb_data = imm_u;
      WB_PCIMM: wb_data = pc_imm;
      default:  wb_data = alu_y;
    endcase
  end

  // Gating with RESET_N keeps an edge that lands during reset from writing state.
  assign reg_we = RESET_N && (wb_sel != WB_NONE) && (rd != 5'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      pc <= '0;
    else
      pc <= next_pc;
  end

`ifdef CORE_REGFILE_CLEAR_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd] <= wb_data;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (reg_we)
      regs[rd] <= wb_data;
  end
`endif

  assign bus.iaddr    = pc;
  assign bus.daddr    = alu_y;
  assign bus.ddata_w  = rs2_val;
  assign bus.MemRead  = mem_rd && RESET_N;
  assign bus.MemWrite = mem_wr && RESET_N;
  assign bus.d_rw     = mem_wr && RESET_N;

endmodule

// File: tb/tb_core_rv32i.sv
// tb/tb_core_rv32i.sv - self-checking bench for core_rv32i
module tb_core_rv32i;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  core_rv32i_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  core_rv32i #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];
  logic        ram_fill = 1'b0;
  logic [31:0] ram_seed = 32'd0;

  assign bus.idata   = rom[bus.iaddr[11:2]];
  assign bus.ddata_r = ram[bus.daddr[11:2]];

  function automatic logic [31:0] pat(input int i, input logic [31:0] s);
    return (32'(i) * 32'h9E3779B1) ^ s;
  endfunction

  always @(posedge CLK) begin
    if (ram_fill) begin
      for (int i = 0; i < 1024; i++) ram[i] = pat(i, ram_seed);
    end else if (bus.MemWrite) begin
      ram[bus.daddr[11:2]] = bus.ddata_w;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds reset for two edges and refills RAM; returns at a negedge, reset still low.
  task automatic do_reset(input logic [31:0] seed);
    RESET_N  = 1'b0;
    ram_seed = seed;
    ram_fill = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ram_fill = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- architectural reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic [31:0] m_mem [1024];

  task automatic model_eval(output logic e_rd, output logic e_wr, output logic [31:0] e_addr,
                            output logic [31:0] e_wd, output logic [31:0] n_pc,
                            output logic w_en, output logic [31:0] w_val);
    logic [31:0] ins, a, b, ii, si, bi, ui, ji;
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic        tk;
    ins = rom[m_pc[11:2]];
    f3  = ins[14:12];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ui  = {ins[31:12], 12'd0};
    ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'd0; e_wd = b;
    n_pc = m_pc + 32'd4; w_en = 1'b0; w_val = 32'd0; tk = 1'b0;
    case (ins[6:0])
      7'h37: begin w_en = 1'b1; w_val = ui; end
      7'h17: begin w_en = 1'b1; w_val = m_pc + ui; end
      7'h6F: begin w_en = 1'b1; w_val = m_pc + 32'd4; n_pc = m_pc + ji; end
      7'h67: begin w_en = 1'b1; w_val = m_pc + 32'd4; n_pc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) n_pc = m_pc + bi;
      end
      7'h03: if (f3 == 3'd2) begin
        e_rd = 1'b1; e_addr = a + ii; w_en = 1'b1; w_val = m_mem[e_addr[11:2]];
      end
      7'h23: if (f3 == 3'd2) begin
        e_wr = 1'b1; e_addr = a + si;
      end
      7'h13: begin
        w_en = 1'b1;
        sh = ins[24:20];
        case (f3)
          3'd0: w_val = a + ii;
          3'd1: w_val = a << sh;
          3'd2: w_val = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: w_val = (a < ii) ? 32'd1 : 32'd0;
          3'd4: w_val = a ^ ii;
          3'd5: w_val = ins[30] ? 32'($signed(a) >>> sh) : (a >> sh);
          3'd6: w_val = a | ii;
          default: w_val = a & ii;
        endcase
      end
      7'h33: begin
        w_en = 1'b1;
        sh = b[4:0];
        case (f3)
          3'd0: w_val = ins[30] ? a - b : a + b;
          3'd1: w_val = a << sh;
          3'd2: w_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: w_val = (a < b) ? 32'd1 : 32'd0;
          3'd4: w_val = a ^ b;
          3'd5: w_val = ins[30] ? 32'($signed(a) >>> sh) : (a >> sh);
          3'd6: w_val = a | b;
          default: w_val = a & b;
        endcase
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [19:0] u20;
    logic [6:0]  f7, op;
    int k;
    r   = $urandom;
    rd  = r[4:0];
    rs1 = r[9:5];
    rs2 = r[14:10];
    f3  = r[17:15];
    i12 = 12'($urandom);
    u20 = 20'($urandom);
    b13 = {13'($urandom) & 13'h1FFE};
    if (b13 == 13'd0) b13 = 13'd4;
    j21 = {21'($urandom) & 21'h1FFFFE};
    if (j21 == 21'd0) j21 = 21'd8;
    k = $urandom_range(0, 11);
    case (k)
      0: return {u20, rd, 7'h37};
      1: return {u20, rd, 7'h17};
      2: return {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F};
      3: return {i12, rs1, 3'b000, rd, 7'h67};
      4: return {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
      5: return {i12, rs1, 3'b010, rd, 7'h03};
      6: return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
      7, 8: begin
        if (f3 == 3'd1) return {7'd0, rs2, rs1, f3, rd, 7'h13};
        if (f3 == 3'd5) return {1'b0, r[20], 5'd0, rs2, rs1, f3, rd, 7'h13};
        return {i12, rs1, f3, rd, 7'h13};
      end
      9, 10: begin
        f7 = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, r[20], 5'd0} : 7'd0;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      default: begin
        op = r[21] ? 7'h73 : (r[22] ? 7'h0F : 7'h7F);
        return {25'($urandom), op};
      end
    endcase
  endfunction

  // ---------------- directed program table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    logic        e_rd, e_wr, w_en;
    logic [31:0] e_addr, e_wd, n_pc, w_val, seed, ins;

    tbl[0]  = '{32'h00500093, 32'h00, 1'b0, 1'b0, 32'd0,  32'd0};   // addi x1,x0,5
    tbl[1]  = '{32'h00700113, 32'h04, 1'b0, 1'b0, 32'd0,  32'd0};   // addi x2,x0,7
    tbl[2]  = '{32'h002081B3, 32'h08, 1'b0, 1'b0, 32'd0,  32'd0};   // add x3,x1,x2
    tbl[3]  = '{32'h00302423, 32'h0C, 1'b0, 1'b1, 32'd8,  32'd12};  // sw x3,8(x0)
    tbl[4]  = '{32'h00802203, 32'h10, 1'b1, 1'b0, 32'd8,  32'd0};   // lw x4,8(x0)
    tbl[5]  = '{32'h008000EF, 32'h14, 1'b0, 1'b0, 32'd0,  32'd0};   // jal x1,+8
    tbl[6]  = '{32'h00102623, 32'h1C, 1'b0, 1'b1, 32'd12, 32'h18};  // sw x1,12(x0)
    tbl[7]  = '{32'h00402823, 32'h20, 1'b0, 1'b1, 32'd16, 32'd12};  // sw x4,16(x0)
    tbl[8]  = '{32'h06300013, 32'h24, 1'b0, 1'b0, 32'd0,  32'd0};   // addi x0,x0,99
    tbl[9]  = '{32'hFFFFFFFF, 32'h28, 1'b0, 1'b0, 32'd0,  32'd0};   // illegal
    tbl[10] = '{32'h00002A23, 32'h2C, 1'b0, 1'b1, 32'd20, 32'd0};   // sw x0,20(x0)
    tbl[11] = '{32'h00000063, 32'h30, 1'b0, 1'b0, 32'd0,  32'd0};   // beq x0,x0,0
    tbl[12] = '{32'h00000063, 32'h30, 1'b0, 1'b0, 32'd0,  32'd0};
    tbl[13] = '{32'h00000063, 32'h30, 1'b0, 1'b0, 32'd0,  32'd0};

    for (int i = 0; i < 1024; i++) rom[i] = 32'h00000013;
    for (int i = 0; i < NV; i++) rom[tbl[i].pc[11:2]] = tbl[i].instr;

    @(negedge CLK);
    do_reset(32'h1234_5678);
    check("rst_iaddr",    bus.iaddr, 32'd0);
    check("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rst_memread",  {31'd0, bus.MemRead}, 32'd0);
    check("rst_d_rw",     {31'd0, bus.d_rw}, 32'd0);
    RESET_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      check($sformatf("tbl%0d_iaddr", i), bus.iaddr, tbl[i].pc);
      check($sformatf("tbl%0d_memread", i),  {31'd0, bus.MemRead},  {31'd0, tbl[i].rd});
      check($sformatf("tbl%0d_memwrite", i), {31'd0, bus.MemWrite}, {31'd0, tbl[i].wr});
      check($sformatf("tbl%0d_d_rw", i),     {31'd0, bus.d_rw},     {31'd0, tbl[i].wr});
      if (tbl[i].rd || tbl[i].wr) check($sformatf("tbl%0d_daddr", i), bus.daddr, tbl[i].addr);
      if (tbl[i].wr) check($sformatf("tbl%0d_wdata", i), bus.ddata_w, tbl[i].wdata);
      @(posedge CLK);
      @(negedge CLK);
    end
    check("ram_word2", ram[2], 32'd12);
    check("ram_word3", ram[3], 32'h18);
    check("ram_word4", ram[4], 32'd12);
    check("ram_word5", ram[5], 32'd0);

    // Reset asserted while a store is on the bus: strobe drops at once, RAM untouched.
    seed = 32'hA5A5_0F0F;
    do_reset(seed);
    RESET_N = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("abort_pre_iaddr", bus.iaddr, 32'h0C);
    check("abort_pre_memwrite", {31'd0, bus.MemWrite}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("abort_iaddr", bus.iaddr, 32'd0);
    check("abort_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("abort_ram_word2", ram[2], pat(2, seed));
    check("abort_hold_iaddr", bus.iaddr, 32'd0);

    // Random programs: 31 addi prologue defines every register, then random code.
    for (int p = 0; p < 4; p++) begin
      seed = $urandom;
      for (int i = 0; i < 31; i++) begin
        ins = {12'($urandom), 5'd0, 3'b000, 5'(i + 1), 7'h13};
        rom[i] = ins;
      end
      for (int i = 31; i < 1024; i++) rom[i] = gen_instr();
      do_reset(seed);
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
      for (int i = 0; i < 1024; i++) m_mem[i] = pat(i, seed);
      RESET_N = 1'b1;
      for (int c = 0; c < 800; c++) begin
        model_eval(e_rd, e_wr, e_addr, e_wd, n_pc, w_en, w_val);
        check("rnd_iaddr",    bus.iaddr, m_pc);
        check("rnd_memread",  {31'd0, bus.MemRead},  {31'd0, e_rd});
        check("rnd_memwrite", {31'd0, bus.MemWrite}, {31'd0, e_wr});
        check("rnd_d_rw",     {31'd0, bus.d_rw},     {31'd0, e_wr});
        if (e_rd || e_wr) check("rnd_daddr", bus.daddr, e_addr);
        if (e_wr) check("rnd_wdata", bus.ddata_w, e_wd);
        @(posedge CLK);
        if (w_en && rom[m_pc[11:2]][11:7] != 5'd0) m_x[rom[m_pc[11:2]][11:7]] = w_val;
        if (e_wr) m_mem[e_addr[11:2]] = e_wd;
        m_pc = n_pc;
        @(negedge CLK);
      end
      for (int i = 0; i < 1024; i++)
        if (ram[i] !== m_mem[i]) check($sformatf("rnd_ram%0d", i), ram[i], m_mem[i]);
      check("rnd_ram_sample", ram[p * 37], m_mem[p * 37]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
